obstacle_layer: RTL
===================

Name: obstacle_layer

Overview:
Pixel-layer responder for the VGA pipeline. It consumes the beam position and game ticks from the graphics top and returns the per-pixel obstacle color bit that the graphics top feeds into its priority encoder and collision detector. It owns obstacle spawning, scrolling, difficulty ramp and the score-increment pulse.

Parameters:
CONV, 0, LSBs dropped from incoming hpos/vpos (must match the graphics top)
NUM_OBS, 2, obstacle slots
OBS_W, 16, obstacle width in pixels
OBS_H, 32, obstacle height in pixels
GROUND_Y, 400, first row below the obstacle (bottom edge exclusive)
SCREEN_W, 640, spawn x coordinate
MIN_GAP, 12, minimum ticks between spawns
SPEED_INIT, 4, initial scroll step in pixels/tick
SPEED_MAX, 12, scroll step saturation value

Ports:
clk  in  1  system pixel clock
rst_n  in  1  asynchronous active-low reset
i_hpos  in  10-CONV  beam x (hpos[9:CONV])
i_vpos  in  10-CONV  beam y (vpos[9:CONV])
i_game_tick  in  1  one-cycle 20 Hz tick
i_game_start_pulse  in  1  one-cycle start/restart request
i_collision  in  1  level; sticky collision flag from the graphics top
o_color_obstacle  out  1  obstacle covers the pixel at the position presented one cycle earlier
o_obstacle_passed  out  1  one-cycle pulse when an obstacle leaves the screen
o_speed  out  4  current scroll step
o_state  out  2  00 IDLE, 01 RUN, 10 HALT

Behaviour:
- Reset (rst_n=0, async): state IDLE, all slots inactive, x=0, gap counter=0, speed=SPEED_INIT, tick counter=0, LFSR=8'hA5, all outputs 0 (o_speed=SPEED_INIT). Takes effect immediately, including mid-frame or mid-tick.
- FSM: IDLE->RUN on start pulse. RUN->HALT when i_collision=1. HALT->RUN on start pulse. A start pulse in any state clears all slots, sets gap counter=0, speed=SPEED_INIT, tick counter=0, and enters RUN.
- Priority within one cycle: start pulse > collision > tick. Tick coinciding with start or with collision in RUN is ignored (no move, no spawn).
- Slot x is 11-bit two's complement. On a tick in RUN, each active slot takes x <= x - speed. If the new x satisfies x + OBS_W <= 0, the slot is deactivated and o_obstacle_passed pulses the next cycle. It pulses once even if several slots retire on the same tick.
- Spawn on a tick in RUN. If gap counter = 0 and a free slot exists, the lowest-index free slot is activated with x=SCREEN_W. Gap counter is reloaded with MIN_GAP + LFSR[3:0]. A spawned slot is not moved on its spawn tick. If no slot is free, the gap counter stays 0 and spawn is retried on the next tick. Otherwise the gap counter decrements by 1 per tick.
- Difficulty: the tick counter is 8-bit and counts RUN ticks. On wrap 255->0, speed increments by 1, saturating at SPEED_MAX.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. It advances every clock in every state and is never loaded except by reset.
- Pixel test: full-res px = i_hpos<<CONV, py = i_vpos<<CONV, both zero-extended to 11 bits signed. A pixel is a hit if any slot has active && x <= px < x+OBS_W && GROUND_Y-OBS_H <= py < GROUND_Y.
- o_color_obstacle is registered. Latency is exactly 1 clock from i_hpos/i_vpos. The output is forced 0 in IDLE. In HALT, slots stay frozen and are still drawn.
- A partially off-screen obstacle (x<0) draws only its visible columns. x >= SCREEN_W draws nothing.

Test Plan:
- Reset release, no start -> o_state=00, o_color_obstacle=0 for a full frame, o_speed=4.
- Start pulse, then 1 tick -> slot0 active at x=640. Next tick x=636. Presenting hpos=636, vpos=380 gives o_color_obstacle=1 one cycle later. hpos=652 or vpos=400 gives 0.
- Run until slot0 x=-12, then tick (x=-16) -> slot0 deactivates and o_obstacle_passed is high for exactly 1 cycle.
- Assert i_collision with a tick in the same cycle -> o_state=10, x unchanged, obstacle still drawn. Then start pulse -> o_state=01, no slots active, o_speed=4.
- 256 RUN ticks -> o_speed=5. Continue to 2304 ticks -> o_speed=12 and holds at 12.
- Drop rst_n mid-frame while RUN with active slots -> all outputs 0 asynchronously (o_speed=4) and o_state=00 before the next clk edge.

Source files
------------

// File: rtl/obstacle_layer.sv
// Obstacle layer for the VGA pipeline: spawns, scrolls and retires obstacles on game ticks,
// ramps scroll speed, and returns a registered per-pixel obstacle hit bit.
`timescale 1ns/1ps
module obstacle_layer #(
    parameter int CONV       = 0,
    parameter int NUM_OBS    = 2,
    parameter int OBS_W      = 16,
    parameter int OBS_H      = 32,
    parameter int GROUND_Y   = 400,
    parameter int SCREEN_W   = 640,
    parameter int MIN_GAP    = 12,
    parameter int SPEED_INIT = 4,
    parameter int SPEED_MAX  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9-CONV:0]  i_hpos,
    input  logic [9-CONV:0]  i_vpos,
    input  logic             i_game_tick,
    input  logic             i_game_start_pulse,
    input  logic             i_collision,
    output logic             o_color_obstacle,
    output logic             o_obstacle_passed,
    output logic [3:0]       o_speed,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    localparam logic signed [11:0] OBS_W_S    = 12'(OBS_W);
    localparam logic signed [11:0] SCREEN_W_S = 12'(SCREEN_W);
    localparam logic signed [11:0] TOP_Y_S    = 12'(GROUND_Y - OBS_H);
    localparam logic signed [11:0] GROUND_Y_S = 12'(GROUND_Y);

    state_t                    state_q, state_d;
    logic [NUM_OBS-1:0]        active_q, active_d;
    logic signed [10:0]        x_q [NUM_OBS];
    logic signed [10:0]        x_d [NUM_OBS];
    logic [7:0]                gap_q, gap_d;
    logic [3:0]                speed_q, speed_d;
    logic [7:0]                tick_cnt_q, tick_cnt_d;
    logic [7:0]                lfsr_q, lfsr_d;
    logic                      color_q, color_d;
    logic                      passed_q, passed_d;

    logic                      found;
    logic                      hit;
    logic signed [11:0]        nx;
    logic signed [11:0]        xs;
    logic signed [11:0]        px;
    logic signed [11:0]        py;

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        x_d        = x_q;
        gap_d      = gap_q;
        speed_d    = speed_q;
        tick_cnt_d = tick_cnt_q;
        passed_d   = 1'b0;
        found      = 1'b0;
        nx         = '0;
        // x^8+x^6+x^5+x^4+1, shifting towards the MSB
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        if (i_game_start_pulse) begin
            state_d    = ST_RUN;
            active_d   = '0;
            for (int unsigned i = 0; i < NUM_OBS; i++) x_d[i] = '0;
            gap_d      = '0;
            speed_d    = 4'(SPEED_INIT);
            tick_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            if (i_collision) begin
                state_d = ST_HALT;
            end else if (i_game_tick) begin
                tick_cnt_d = tick_cnt_q + 8'd1;
                if (tick_cnt_q == 8'hFF && speed_q < 4'(SPEED_MAX))
                    speed_d = speed_q + 4'd1;

                for (int unsigned i = 0; i < NUM_OBS; i++) begin
                    if (active_q[i]) begin
                        nx     = {x_q[i][10], x_q[i]} - {8'b0, speed_q};
                        x_d[i] = nx[10:0];
                        if (nx + OBS_W_S <= 12'sd0) begin
                            active_d[i] = 1'b0;
                            passed_d    = 1'b1;
                        end
                    end
                end

                // Free slots are judged before this tick's retirements, so a freshly spawned
                // slot is never moved in the tick that creates it.
                if (gap_q == 8'd0) begin
                    for (int unsigned i = 0; i < NUM_OBS; i++) begin
                        if (!found && !active_q[i]) begin
                            active_d[i] = 1'b1;
                            x_d[i]      = SCREEN_W_S[10:0];
                            found       = 1'b1;
                        end
                    end
                    if (found) gap_d = 8'(MIN_GAP) + {4'b0, lfsr_q[3:0]};
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
        end
    end

    always_comb begin
        px  = 12'(i_hpos) << CONV;
        py  = 12'(i_vpos) << CONV;
        hit = 1'b0;
        xs  = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            xs = {x_q[i][10], x_q[i]};
            if (active_q[i] && xs < SCREEN_W_S && xs <= px && px < xs + OBS_W_S &&
                TOP_Y_S <= py && py < GROUND_Y_S)
                hit = 1'b1;
        end
        color_d = (state_q != ST_IDLE) && hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            active_q   <= '0;
            for (int unsigned i = 0; i < NUM_OBS; i++) x_q[i] <= '0;
            gap_q      <= '0;
            speed_q    <= 4'(SPEED_INIT);
            tick_cnt_q <= '0;
            lfsr_q     <= 8'hA5;
            color_q    <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            x_q        <= x_d;
            gap_q      <= gap_d;
            speed_q    <= speed_d;
            tick_cnt_q <= tick_cnt_d;
            lfsr_q     <= lfsr_d;
            color_q    <= color_d;
            passed_q   <= passed_d;
        end
    end

    assign o_color_obstacle  = color_q;
    assign o_obstacle_passed = passed_q;
    assign o_speed           = speed_q;
    assign o_state           = state_q;

endmodule
